// File: rtl/xcorr_pkg.sv
// rtl/xcorr_pkg.sv - shared types and helpers for windowed xcorr blocks
package xcorr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEARCH  = 2'd1,
      HOLDOFF = 2'd2
   } xpk_state_t;

   // Window length as actually used: zero means one sample, oversize saturates.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max);
      if (len == 0)
         return 1;
      else if (len > max)
         return max;
      else
         return len;
   endfunction

endpackage

// File: rtl/xcorr_max_track.sv
// rtl/xcorr_max_track.sv - running maximum and its position, ties keep earliest
module xcorr_max_track #(
   parameter int W  = 24,
   parameter int PW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic          upd,
   input  logic [W-1:0]  din,
   input  logic [PW-1:0] pos,
   output logic [W-1:0]  nxt_val,
   output logic [PW-1:0] nxt_pos
);

   logic [W-1:0]  max_q;
   logic [PW-1:0] pos_q;

   // Next max/pos including the current sample, so the owner can report on the same edge.
   always_comb begin
      nxt_val = max_q;
      nxt_pos = pos_q;
      if (init) begin
         nxt_val = din;
         nxt_pos = pos;
      end else if (upd && (din > max_q)) begin
         nxt_val = din;
         nxt_pos = pos;
      end
   end

   // Running max register pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_q <= '0;
         pos_q <= '0;
      end else begin
         max_q <= nxt_val;
         pos_q <= nxt_pos;
      end
   end

endmodule

// File: rtl/xcorr_peak_detect.sv
// rtl/xcorr_peak_detect.sv - windowed peak search on xcorr magnitude, optional holdoff via XCORR_HOLDOFF_EN
module xcorr_peak_detect
   import xcorr_pkg::*;
#(
   parameter  int WND_MAX  = 64,
   parameter  int WDTH_CRR = 24,
   localparam int POS_W    = (WND_MAX > 1) ? $clog2(WND_MAX) : 1,
   localparam int LEN_W    = $clog2(WND_MAX + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [WDTH_CRR-1:0] corr_in,
   input  logic [WDTH_CRR-1:0] thr_lvl,
   input  logic [LEN_W-1:0]    wnd_len,
`ifdef XCORR_HOLDOFF_EN
   input  logic [LEN_W-1:0]    holdoff_len,
`endif
   output logic                osop,
   output logic [WDTH_CRR-1:0] peak_val,
   output logic [POS_W-1:0]    peak_pos,
   output logic                busy
);

   xpk_state_t          state_q, state_d, end_state;
   logic [LEN_W-1:0]    cnt_q, len_q, len_clamped;
   logic                trig, wnd_end, trk_upd;
   logic [POS_W-1:0]    trk_pos_in, trk_pos_d;
   logic [WDTH_CRR-1:0] trk_val_d;
   logic                osop_q;
   logic [WDTH_CRR-1:0] peak_val_q;
   logic [POS_W-1:0]    peak_pos_q;

   assign len_clamped = LEN_W'(clamp_len(32'(wnd_len), 32'(WND_MAX)));
   assign trk_pos_in  = trig ? '0 : cnt_q[POS_W-1:0];

`ifdef XCORR_HOLDOFF_EN
   logic [LEN_W-1:0] hold_q, hold_cnt_q;

   assign end_state = (holdoff_len == '0) ? IDLE : HOLDOFF;

   // Holdoff length latch and valid-sample counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q     <= '0;
         hold_cnt_q <= '0;
      end else if (wnd_end) begin
         hold_q     <= holdoff_len;
         hold_cnt_q <= '0;
      end else if ((state_q == HOLDOFF) && in_valid) begin
         hold_cnt_q <= hold_cnt_q + LEN_W'(1);
      end
   end
`else
   assign end_state = IDLE;
`endif

   // Next state and per-cycle control strobes.
   always_comb begin
      state_d = state_q;
      trig    = 1'b0;
      wnd_end = 1'b0;
      trk_upd = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && (corr_in > thr_lvl)) begin
               trig = 1'b1;
               if (len_clamped == LEN_W'(1)) begin
                  wnd_end = 1'b1;
                  state_d = end_state;
               end else begin
                  state_d = SEARCH;
               end
            end
         end
         SEARCH: begin
            if (in_valid) begin
               trk_upd = 1'b1;
               if (cnt_q == (len_q - LEN_W'(1))) begin
                  wnd_end = 1'b1;
                  state_d = end_state;
               end
            end
         end
`ifdef XCORR_HOLDOFF_EN
         HOLDOFF: begin
            if (in_valid && (hold_cnt_q == (hold_q - LEN_W'(1))))
               state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   xcorr_max_track #(
      .W  (WDTH_CRR),
      .PW (POS_W)
   ) u_max_track (
      .clk     (clk),
      .rst     (rst),
      .init    (trig),
      .upd     (trk_upd),
      .din     (corr_in),
      .pos     (trk_pos_in),
      .nxt_val (trk_val_d),
      .nxt_pos (trk_pos_d)
   );

   // State, window counter/length latch and report registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         osop_q     <= 1'b0;
         peak_val_q <= '0;
         peak_pos_q <= '0;
      end else begin
         state_q <= state_d;
         osop_q  <= wnd_end;
         if (trig) begin
            cnt_q <= LEN_W'(1);
            len_q <= len_clamped;
         end else if ((state_q == SEARCH) && in_valid) begin
            cnt_q <= cnt_q + LEN_W'(1);
         end
         if (wnd_end) begin
            peak_val_q <= trk_val_d;
            peak_pos_q <= trk_pos_d;
         end
      end
   end

   assign osop     = osop_q;
   assign peak_val = peak_val_q;
   assign peak_pos = peak_pos_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// tb/tb_xcorr_peak_detect.sv - scoreboard bench for xcorr_peak_detect
module tb_xcorr_peak_detect;

   localparam int WND_MAX  = 16;
   localparam int WDTH_CRR = 24;
   localparam int POS_W    = 4;
   localparam int LEN_W    = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic [WDTH_CRR-1:0] corr_in;
   logic [WDTH_CRR-1:0] thr_lvl;
   logic [LEN_W-1:0]    wnd_len;
   logic [LEN_W-1:0]    holdoff_len;
   logic                osop;
   logic [WDTH_CRR-1:0] peak_val;
   logic [POS_W-1:0]    peak_pos;
   logic                busy;

   typedef struct {
      logic [WDTH_CRR-1:0] val;
      logic [POS_W-1:0]    pos;
      int                  cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   per;
   int   t1[10] = '{0, 0, 150, 200, 180, 90, 300, 300, 10, 5};

   xcorr_peak_detect #(
      .WND_MAX  (WND_MAX),
      .WDTH_CRR (WDTH_CRR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .corr_in     (corr_in),
      .thr_lvl     (thr_lvl),
      .wnd_len     (wnd_len),
`ifdef XCORR_HOLDOFF_EN
      .holdoff_len (holdoff_len),
`endif
      .osop        (osop),
      .peak_val    (peak_val),
      .peak_pos    (peak_pos),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic [WDTH_CRR-1:0] d);
      in_valid = v;
      corr_in  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_peak(input logic [WDTH_CRR-1:0] v, input logic [POS_W-1:0] p);
      exp_q.push_back('{val: v, pos: p, cyc: cyc});
   endtask

   // Monitor: every osop pops one expected report.
   always @(negedge clk) begin
      if (osop === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_osop: got pulse at cycle %0d (peak_val=%0d peak_pos=%0d), expected none",
                     cyc, peak_val, peak_pos);
         end else begin
            mon_e = exp_q.pop_front();
            check("osop_cycle", cyc, mon_e.cyc);
            check("peak_val", peak_val, mon_e.val);
            check("peak_pos", peak_pos, mon_e.pos);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      corr_in     = '0;
      thr_lvl     = 24'd100;
      wnd_len     = 5'd8;
      holdoff_len = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_osop", osop, 0);
      check("reset_busy", busy, 0);
      check("reset_peak_val", peak_val, 0);
      check("reset_peak_pos", peak_pos, 0);
      rst = 1'b0;

      // Basic window, valid every cycle.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 24'(t1[i]));
         if (i == 2) begin
            @(negedge clk);
            check("busy_after_trigger", busy, 1);
         end
         if (i == 9) expect_peak(24'd300, 4'd4);
      end
      drive(1'b0, '0);
      @(negedge clk);
      check("busy_after_window", busy, 0);

      // Equal-to-threshold never triggers.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 24'd100);
         @(negedge clk);
         check("thr_equal_busy", busy, 0);
         check("thr_equal_osop", osop, 0);
      end

      // Gapped valid, invalid filler above threshold, wnd_len change ignored mid-window.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 24'(t1[i]));
         if (i == 3) wnd_len = 5'd3;
         if (i == 9) expect_peak(24'd300, 4'd4);
         drive(1'b0, 24'd999);
      end
      drive(1'b0, '0);

      // Length 1 and 0, back to back.
      wnd_len = 5'd1;
      drive(1'b1, 24'd500);
      expect_peak(24'd500, 4'd0);
      wnd_len = 5'd0;
      drive(1'b1, 24'd500);
      expect_peak(24'd500, 4'd0);
      drive(1'b1, '0);
      drive(1'b0, '0);

      // Oversize length saturates at WND_MAX.
      wnd_len = 5'd31;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, (i == 10) ? 24'd1000 : 24'(150 + i));
         if (i == 15) expect_peak(24'd1000, 4'd10);
      end
      drive(1'b1, 24'd50);
      drive(1'b0, '0);

      // Reset mid-window aborts the report.
      wnd_len = 5'd8;
      drive(1'b1, 24'd150);
      drive(1'b1, 24'd160);
      drive(1'b1, 24'd170);
      rst = 1'b1;
      drive(1'b1, 24'd400);
      rst = 1'b0;
      @(negedge clk);
      check("midreset_osop", osop, 0);
      check("midreset_busy", busy, 0);
      check("midreset_peak_val", peak_val, 0);
      check("midreset_peak_pos", peak_pos, 0);
      wnd_len = 5'd4;
      drive(1'b1, 24'd120);
      drive(1'b1, 24'd110);
      drive(1'b1, 24'd130);
      drive(1'b1, 24'd105);
      expect_peak(24'd130, 4'd2);
      drive(1'b0, '0);

      // Continuous stream above threshold.
`ifdef XCORR_HOLDOFF_EN
      holdoff_len = 5'd3;
      per = 7;
`else
      per = 4;
`endif
      wnd_len = 5'd4;
      for (int i = 0; i < 3 * per; i++) begin
         drive(1'b1, 24'd200);
         if ((i % per) == 3) expect_peak(24'd200, 4'd0);
      end
      holdoff_len = '0;
      repeat (3) drive(1'b0, '0);

      check("missing_osops", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
